// File: rtl/video_dvp_transmitter.sv
// rtl/video_dvp_transmitter.sv - 16-bit pixel stream to 8-bit DVP bus serialiser, high byte first.
module video_dvp_transmitter #(
  parameter logic       CMOS_VSYNC_VALID = 1'b1,
  parameter logic [9:0] IMG_HDISP        = 10'd640,
  parameter logic [9:0] IMG_VDISP        = 10'd480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [15:0] per_frame_data,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic [9:0]  line_cnt,
  output logic        frame_done,
  output logic        err_overflow,
  output logic        err_geometry
);

  typedef enum logic [1:0] {IDLE, BYTE_HI, BYTE_LO} state_t;

  state_t      state;
  logic [15:0] pixel;
  logic [9:0]  pix_cnt;
  logic        href_d;
  logic        vsync_d;
  logic        accept;
  logic        href_fall;
  logic        vsync_fall;
  logic [9:0]  line_next;

  assign accept     = per_frame_href & per_frame_clken;
  assign href_fall  = href_d & ~per_frame_href;
  assign vsync_fall = vsync_d & ~per_frame_vsync;

  // Line count including a line closing this cycle, so a coincident frame check sees it.
  always_comb begin
    line_next = line_cnt;
    if (href_fall && line_cnt != 10'h3FF)
      line_next = line_cnt + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pixel        <= 16'h0000;
      pix_cnt      <= 10'd0;
      href_d       <= 1'b0;
      vsync_d      <= 1'b0;
      cmos_vsync   <= ~CMOS_VSYNC_VALID;
      cmos_href    <= 1'b0;
      cmos_data    <= 8'h00;
      line_cnt     <= 10'd0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
      err_geometry <= 1'b0;
    end else begin
      href_d     <= per_frame_href;
      vsync_d    <= per_frame_vsync;
      cmos_vsync <= per_frame_vsync ? CMOS_VSYNC_VALID : ~CMOS_VSYNC_VALID;
      frame_done <= vsync_fall;

      case (state)
        IDLE: begin
          cmos_href <= 1'b0;
          cmos_data <= 8'h00;
          if (accept) begin
            pixel <= per_frame_data;
            state <= BYTE_HI;
          end
        end
        BYTE_HI: begin
          cmos_href <= 1'b1;
          cmos_data <= pixel[15:8];
          state     <= BYTE_LO;
          if (accept)
            err_overflow <= 1'b1;
        end
        BYTE_LO: begin
          cmos_href <= 1'b1;
          cmos_data <= pixel[7:0];
          if (accept) begin
            pixel <= per_frame_data;
            state <= BYTE_HI;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Dropped pixels still count toward line geometry.
      if (href_fall) begin
        if (pix_cnt != IMG_HDISP)
          err_geometry <= 1'b1;
        pix_cnt <= 10'd0;
      end else if (accept && pix_cnt != 10'h3FF) begin
        pix_cnt <= pix_cnt + 10'd1;
      end

      if (vsync_fall) begin
        if (line_next != IMG_VDISP)
          err_geometry <= 1'b1;
        line_cnt <= 10'd0;
      end else begin
        line_cnt <= line_next;
      end
    end
  end

endmodule

// File: tb/tb_video_dvp_transmitter.sv
// tb/tb_video_dvp_transmitter.sv - randomized self-checking bench for video_dvp_transmitter.
module tb_video_dvp_transmitter;

  localparam int HD = 16;
  localparam int VD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic [15:0] per_frame_data = 16'h0000;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic [9:0]  line_cnt;
  logic        frame_done;
  logic        err_overflow;
  logic        err_geometry;

  video_dvp_transmitter #(
    .CMOS_VSYNC_VALID(1'b1),
    .IMG_HDISP(10'(HD)),
    .IMG_VDISP(10'(VD))
  ) dut (
    .clk(clk),
    .rst(rst),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken),
    .per_frame_data(per_frame_data),
    .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href),
    .cmos_data(cmos_data),
    .line_cnt(line_cnt),
    .frame_done(frame_done),
    .err_overflow(err_overflow),
    .err_geometry(err_geometry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: expected output byte per edge index, plus frame bookkeeping.
  logic [7:0] exp_byte [int];
  int  pix_m = 0, line_m = 0, last_taken = -10;
  bit  ov_m = 0, geo_m = 0, fd_m = 0, vs_m = 0, prev_hr = 0, prev_vs = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model(input int k, input logic r, input logic vs, input logic hr,
                       input logic ck, input logic [15:0] d);
    if (r) begin
      pix_m = 0; line_m = 0; ov_m = 0; geo_m = 0; fd_m = 0; vs_m = 0;
      prev_hr = 0; prev_vs = 0; last_taken = -10;
      if (exp_byte.exists(k)) exp_byte.delete(k);
      if (exp_byte.exists(k + 1)) exp_byte.delete(k + 1);
    end else begin
      vs_m = vs;
      fd_m = prev_vs & ~vs;
      if (hr && ck) begin
        if (pix_m != 1023) pix_m++;
        if (k == last_taken + 1) begin
          ov_m = 1;
        end else begin
          last_taken = k;
          exp_byte[k + 1] = d[15:8];
          exp_byte[k + 2] = d[7:0];
        end
      end
      if (prev_hr && !hr) begin
        if (pix_m != HD) geo_m = 1;
        if (line_m != 1023) line_m++;
        pix_m = 0;
      end
      if (fd_m) begin
        if (line_m != VD) geo_m = 1;
        line_m = 0;
      end
      prev_hr = hr;
      prev_vs = vs;
    end
  endtask

  task automatic step(input logic r, input logic vs, input logic hr, input logic ck,
                      input logic [15:0] d);
    int k;
    bit has;
    rst = r; per_frame_vsync = vs; per_frame_href = hr;
    per_frame_clken = ck; per_frame_data = d;
    k = cyc + 1;
    model(k, r, vs, hr, ck, d);
    @(posedge clk);
    #1;
    cyc = k;
    has = exp_byte.exists(k);
    check("href", 16'(cmos_href), 16'(has));
    check("data", 16'(cmos_data), has ? 16'(exp_byte[k]) : 16'h0000);
    check("vsync", 16'(cmos_vsync), 16'(vs_m));
    check("line_cnt", 16'(line_cnt), 16'(line_m));
    check("frame_done", 16'(frame_done), 16'(fd_m));
    check("err_overflow", 16'(err_overflow), 16'(ov_m));
    check("err_geometry", 16'(err_geometry), 16'(geo_m));
    if (has) exp_byte.delete(k);
  endtask

  task automatic idle(input int n, input logic vs);
    for (int i = 0; i < n; i++) step(0, vs, 0, 1'($urandom_range(1)), 16'($urandom()));
  endtask

  // One line; ovp = percent chance of a back-to-back strobe, gmax = widest gap.
  task automatic send_line(input int npix, input int ovp, input int gmax, input logic end_vs);
    int gap;
    for (int p = 0; p < npix; p++) begin
      step(0, 1, 1, 1, 16'($urandom()));
      gap = (int'($urandom_range(99)) < ovp) ? 1 : int'($urandom_range(gmax, 2));
      for (int g = 1; g < gap; g++) step(0, 1, 1, 0, 16'($urandom()));
    end
    step(0, end_vs, 0, 1'($urandom_range(1)), 16'($urandom()));
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 16'h0);
    step(1, 1, 1, 1, 16'hFFFF);

    // Single pixel latency and byte order
    idle(2, 1);
    step(0, 1, 1, 1, 16'hA55A);
    step(0, 1, 1, 0, 16'h0);
    check("single_hi", 16'(cmos_data), 16'h00A5);
    step(0, 1, 0, 0, 16'h0);
    check("single_lo", 16'(cmos_data), 16'h005A);
    step(0, 1, 0, 0, 16'h0);
    check("single_end_href", 16'(cmos_href), 16'h0000);
    step(1, 0, 0, 0, 16'h0);

    // Full-rate line of HD pixels, no errors expected
    idle(2, 1);
    send_line(HD, 0, 2, 1);
    idle(3, 1);
    check("line3_cnt", 16'(line_cnt), 16'd1);
    check("line3_geo", 16'(err_geometry), 16'd0);

    // Back-to-back strobes drop the second pixel and latch overflow
    step(1, 0, 0, 0, 16'h0);
    idle(1, 1);
    step(0, 1, 1, 1, 16'h1122);
    step(0, 1, 1, 1, 16'h3344);
    step(0, 1, 1, 0, 16'h0);
    idle(6, 1);
    check("ovf_sticky", 16'(err_overflow), 16'd1);

    // Short lines: geometry error, frame_done, line_cnt clear
    step(1, 0, 0, 0, 16'h0);
    idle(1, 1);
    for (int l = 0; l < VD; l++) begin
      send_line(HD - 1, 0, 2, 1);
      idle(2, 1);
    end
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    check("frame_geo", 16'(err_geometry), 16'd1);
    check("frame_line0", 16'(line_cnt), 16'd0);

    // Reset between hi and lo byte
    idle(1, 1);
    step(0, 1, 1, 1, 16'hBEEF);
    step(0, 1, 0, 0, 16'h0);
    check("rst_hi", 16'(cmos_data), 16'h00BE);
    step(1, 1, 0, 0, 16'h0);
    check("rst_cut_href", 16'(cmos_href), 16'd0);
    idle(3, 0);

    // Randomized frames, including coincident href/vsync fall
    for (int f = 0; f < 8; f++) begin
      int nl;
      if ($urandom_range(1) == 1) step(1, 0, 0, 0, 16'h0);
      idle(int'($urandom_range(3, 1)), 1);
      nl = int'($urandom_range(VD + 1, VD - 1));
      for (int l = 0; l < nl; l++) begin
        logic last_fall;
        last_fall = (l == nl - 1) && ($urandom_range(1) == 1);
        send_line(int'($urandom_range(HD + 1, HD - 1)), 10, 4, last_fall ? 1'b0 : 1'b1);
        if (!last_fall) idle(int'($urandom_range(3, 1)), (l == nl - 1) ? 1'b0 : 1'b1);
      end
      idle(4, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
